// File: rtl/fighter_if.sv
// Player-input and sprite/hit-detection bundle for one fighter_fsm instance.
// master drives the frame/button/opponent side; slave is the fighter controller.
interface fighter_if #(
  parameter int XW = 10
);
  logic          frame_tick;
  logic          btn_fwd;
  logic          btn_back;
  logic          btn_attack;
  logic          hit_in;
  logic [XW-1:0] x_pos_opponent;
  logic [XW-1:0] x_pos;
  logic [3:0]    state;
  logic          atk_dir;
  logic          hitbox_active;
  logic [4:0]    phase_frame;
  logic [7:0]    hit_count;

  modport master (
    output frame_tick, btn_fwd, btn_back, btn_attack, hit_in, x_pos_opponent,
    input  x_pos, state, atk_dir, hitbox_active, phase_frame, hit_count
  );

  modport slave (
    input  frame_tick, btn_fwd, btn_back, btn_attack, hit_in, x_pos_opponent,
    output x_pos, state, atk_dir, hitbox_active, phase_frame, hit_count
  );
endinterface

// File: rtl/fighter_fsm.sv
// Per-player fighter controller: walking with clamping, neutral/directional attacks, hit/block stun.
// Define FIGHTER_BLOCK_EN to enable blocking (BLOCKSTUN); otherwise every honoured hit is HITSTUN.
//
// state     | meaning
// IDLE      | standing, accepts attack/move/hit
// MOVE_FWD  | walking toward opponent, clamped at opponent +/- SPRITE_W
// MOVE_BWD  | walking away, clamped at arena edge
// ATK_SU    | attack startup
// ATK_ACT   | attack active, hitbox_active=1
// ATK_REC   | attack recovery, then IDLE
// HITSTUN   | stunned after a hit, hit_in ignored
// BLOCKSTUN | stunned after a block, hit_in ignored
module fighter_fsm #(
  parameter int XW         = 10,
  parameter bit FACE_RIGHT = 1'b1,
  parameter int START_X    = 10,
  parameter int MIN_X      = 0,
  parameter int MAX_X      = 639,
  parameter int SPRITE_W   = 64,
  parameter int FWD_STEP   = 3,
  parameter int BWD_STEP   = 2,
  parameter int N_SU       = 4,
  parameter int N_ACT      = 1,
  parameter int N_REC      = 15,
  parameter int D_SU       = 3,
  parameter int D_ACT      = 2,
  parameter int D_REC      = 16,
  parameter int HITSTUN    = 20,
  parameter int BLOCKSTUN  = 12,
  parameter int PUSHBACK   = 8
) (
  input  logic     clk,
  input  logic     reset_n,
  fighter_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_MOVE_FWD  = 4'd1,
    S_MOVE_BWD  = 4'd2,
    S_ATK_SU    = 4'd3,
    S_ATK_ACT   = 4'd4,
    S_ATK_REC   = 4'd5,
    S_HITSTUN   = 4'd6,
    S_BLOCKSTUN = 4'd7
  } state_t;

  typedef logic signed [XW+1:0] sx_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic          dir_q, dir_d;
  logic          hitbox_q, hitbox_d;
  logic [4:0]    phase_q, phase_d;
  logic [7:0]    hits_q, hits_d;
  logic          stunned, is_last, block, legal;

  function automatic logic [4:0] last_frame(input state_t s, input logic dir);
    int n;
    n = 1;
    case (s)
      S_ATK_SU:    n = dir ? D_SU  : N_SU;
      S_ATK_ACT:   n = dir ? D_ACT : N_ACT;
      S_ATK_REC:   n = dir ? D_REC : N_REC;
      S_HITSTUN:   n = HITSTUN;
      S_BLOCKSTUN: n = BLOCKSTUN;
      default:     n = 1;
    endcase
    return 5'(n - 1);
  endfunction

  // Widened signed math so steps past either edge clamp instead of wrapping.
  function automatic logic [XW-1:0] back_move(input logic [XW-1:0] x, input int step);
    sx_t xs;
    xs = $signed({2'b00, x});
    if (FACE_RIGHT) begin
      if (xs - sx_t'(step) < sx_t'(MIN_X)) return XW'(MIN_X);
      return x - XW'(step);
    end else begin
      if (xs + sx_t'(step) > sx_t'(MAX_X - SPRITE_W + 1)) return XW'(MAX_X - SPRITE_W + 1);
      return x + XW'(step);
    end
  endfunction

  // Forward walking never pushes this player backward when already inside the separation limit.
  function automatic logic [XW-1:0] fwd_move(input logic [XW-1:0] x, input logic [XW-1:0] opp);
    sx_t xs, os;
    xs = $signed({2'b00, x});
    os = $signed({2'b00, opp});
    if (FACE_RIGHT) begin
      if (xs + sx_t'(FWD_STEP) <= os - sx_t'(SPRITE_W)) return x + XW'(FWD_STEP);
      if (os - sx_t'(SPRITE_W) > xs) return opp - XW'(SPRITE_W);
      return x;
    end else begin
      if (xs - sx_t'(FWD_STEP) >= os + sx_t'(SPRITE_W)) return x - XW'(FWD_STEP);
      if (os + sx_t'(SPRITE_W) < xs) return opp + XW'(SPRITE_W);
      return x;
    end
  endfunction

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    hits_d  = hits_q;
    legal   = (state_q[3] == 1'b0);
    stunned = (state_q == S_HITSTUN) || (state_q == S_BLOCKSTUN);
    is_last = (phase_q == last_frame(state_q, dir_q));
    block   = 1'b0;
`ifdef FIGHTER_BLOCK_EN
    block   = bus.btn_back && ((state_q == S_IDLE) || (state_q == S_MOVE_BWD));
`endif
    if (bus.frame_tick) begin
      if (!legal) begin
        state_d = S_IDLE;
        phase_d = '0;
        dir_d   = 1'b0;
      end else if (bus.hit_in && !stunned) begin
        state_d = block ? S_BLOCKSTUN : S_HITSTUN;
        phase_d = '0;
        dir_d   = 1'b0;
        x_d     = back_move(x_q, PUSHBACK);
        if (!block && (hits_q != 8'hFF)) hits_d = hits_q + 8'd1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.btn_attack) begin
              state_d = S_ATK_SU;
              dir_d   = 1'b0;
              phase_d = '0;
            end else if (bus.btn_fwd && !bus.btn_back) begin
              state_d = S_MOVE_FWD;
            end else if (bus.btn_back && !bus.btn_fwd) begin
              state_d = S_MOVE_BWD;
            end
          end
          S_MOVE_FWD, S_MOVE_BWD: begin
            x_d = (state_q == S_MOVE_FWD) ? fwd_move(x_q, bus.x_pos_opponent)
                                          : back_move(x_q, BWD_STEP);
            if (bus.btn_attack) begin
              state_d = S_ATK_SU;
              dir_d   = 1'b1;
              phase_d = '0;
            end else if ((state_q == S_MOVE_FWD) ? !bus.btn_fwd : !bus.btn_back) begin
              state_d = S_IDLE;
            end
          end
          default: begin
            phase_d = is_last ? 5'd0 : phase_q + 5'd1;
            if (is_last) begin
              if (state_q == S_ATK_SU) begin
                state_d = S_ATK_ACT;
              end else if (state_q == S_ATK_ACT) begin
                state_d = S_ATK_REC;
              end else begin
                state_d = S_IDLE;
                dir_d   = 1'b0;
              end
            end
          end
        endcase
      end
    end
    hitbox_d = (state_d == S_ATK_ACT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      x_q      <= XW'(START_X);
      dir_q    <= 1'b0;
      hitbox_q <= 1'b0;
      phase_q  <= '0;
      hits_q   <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      dir_q    <= dir_d;
      hitbox_q <= hitbox_d;
      phase_q  <= phase_d;
      hits_q   <= hits_d;
    end
  end

  assign bus.x_pos         = x_q;
  assign bus.state         = state_q;
  assign bus.atk_dir       = dir_q;
  assign bus.hitbox_active = hitbox_q;
  assign bus.phase_frame   = phase_q;
  assign bus.hit_count     = hits_q;

endmodule
